uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//  Robust UART receive endpoint: deserialises the line driven by uart_tx using 16x oversampling,
//  majority-vote bit sampling, optional parity check and stop-bit validation. Delivers each
//  byte through a valid/ready handshake with a one-entry holding register, per-frame error
//  flags and an overrun indication. Sits between the pad-side rx pin and the byte consumer.
// PARAMETERS
//  CLK_FREQ    50000000  system clock frequency, Hz
//  BAUD_RATE   9600      line rate, bit/s
//  OVERSAMPLE  16        sample ticks per bit; even, >= 8
//  DATA_BITS   8         payload bits per frame, 5..9
//  PARITY      0         0 = none, 1 = odd, 2 = even
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  reset_n      in   1          asynchronous, active-low reset
//  rx           in   1          serial line, idle high, asynchronous to clk
//  data_out     out  DATA_BITS  received payload, LSB received first
//  data_valid   out  1          holding register full; held until accepted
//  data_ready   in   1          consumer accepts when data_valid & data_ready
//  parity_err   out  1          parity mismatch for the frame in data_out (0 if PARITY=0)
//  frame_err    out  1          stop bit sampled low for the frame in data_out
//  overrun      out  1          one-cycle pulse: completed frame dropped, register still full
//  busy         out  1          high from start-bit detect until stop-bit mid-sample
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; synchroniser flops reset to 1.
//  - rx passes a 2-flop synchroniser; all decisions use the synchronised value.
//  - Tick: strobe every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer divide;
//    325 at defaults). Divider free-runs; sample counter 0..OVERSAMPLE-1 restarts on start detect.
//  - Bit value = majority of samples OVERSAMPLE/2-1, /2, /2+1 (7,8,9 at 16x).
//  - FSM: IDLE -> START on synced rx = 0 (only when ARMED, see break rule).
//    START: at mid-bit, value 1 -> false start, back to IDLE, no output; value 0 -> DATA.
//    DATA: DATA_BITS bits, LSB first, one per OVERSAMPLE ticks -> PARITY if PARITY!=0 else STOP.
//    PARITY: sample, compare vs odd/even of payload.
//    STOP: at mid-bit decision, go IDLE immediately (half-bit early) so back-to-back frames
//    and +/-2% baud mismatch are tolerated.
//  - Commit: on the clock after the stop decision, if register empty or data_ready high that
//    cycle: load data_out/parity_err/frame_err, data_valid = 1. Otherwise keep old contents and
//    pulse overrun for one cycle; new frame discarded.
//  - Simultaneous accept and commit: old byte consumed, new byte loaded, data_valid stays 1.
//  - Accept with no commit: data_valid -> 0 next cycle; data_out holds last value.
//  - Errored frames are still delivered, flags registered alongside the byte.
//  - Break rule: after frame_err, ARMED clears; re-armed only once synced rx = 1 for one full
//    bit time. After reset ARMED also requires rx = 1 for one full bit time.
//  - reset_n asserted mid-frame: everything clears asynchronously; partial frame lost.
//  - Latency: data_valid rises DIV*OVERSAMPLE/2 + 1..2 clocks after stop-bit centre region
//    starts, plus 2 synchroniser cycles from the line.
// STRUCTURE
//  - uart_pkg: PARITY_NONE/ODD/EVEN constants, FSM state encoding (IDLE, START, DATA,
//    PARITY, STOP), shared divisor function for CLK_FREQ/BAUD_RATE/OVERSAMPLE.
//  - Sub-module uart_baud_tick: parameterised free-running tick strobe, reusable by uart_tx.
//  - Top holds synchroniser, majority voter, FSM, shift register, holding register.
// TESTING  (defaults unless stated; bit time = 5200 clocks, driven by bench BFM)
//  1. data_ready=1, send 0x55 8N1 -> one data_valid pulse, data_out=0x55, errors 0, busy low after.
//  2. PARITY=2, send 0xA3 with parity bit 1 (wrong) -> data_out=0xA3, parity_err=1, frame_err=0.
//  3. Send 0x0F with stop bit 0, hold rx low 3 bit times -> frame_err=1 once; no new frame
//     until rx high one bit time; then 0x96 received clean.
//  4. rx low glitch of 2000 clocks (< half bit) -> no data_valid, busy returns 0, FSM IDLE.
//  5. data_ready=0, back-to-back 0x11, 0x22 -> data_out=0x11 held, overrun pulses exactly once;
//     raise data_ready -> 0x11 accepted, data_valid drops.
//  6. Pull reset_n low mid-DATA of 0xC3 -> outputs 0 asynchronously; after release and idle,
//     0x3C received correctly; also repeat test 1 at BFM baud +2% and -2% -> 0x55 correct.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity constants, receiver FSM encoding and baud divisor helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;

  function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running strobe, one clock-wide pulse every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = cnt_q == W'(DIV - 1);
  assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x-oversampled UART receiver with majority vote, parity/stop checks,
// one-entry valid/ready holding register and break-aware re-arming.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  logic [1:0]           sync_q;
  logic                 rx_s, tick, start, decide, stop_dec, bit_v, par_exp;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, hi_q;
  logic [1:0]           vote_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] sh_q, dout_q;
  logic                 par_q, armed_q;
  logic                 commit_q, cperr_q, cferr_q;
  logic                 dv_q, perr_q, ferr_q, ovr_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i (clk),
    .rst_ni(reset_n),
    .tick_o(tick)
  );

  assign rx_s     = sync_q[1];
  assign start    = state_q == ST_IDLE && armed_q && !rx_s;
  assign decide   = tick && cnt_q == CW'(OVERSAMPLE / 2 + 1);
  assign stop_dec = decide && state_q == ST_STOP;
  assign bit_v    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
  assign par_exp  = PARITY == PARITY_ODD ? ~^sh_q : ^sh_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= ST_IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = start ? ST_START : ST_IDLE;
      ST_START:  if (decide) state_d = bit_v ? ST_IDLE : ST_DATA;
      ST_DATA:   if (decide && bit_q == BW'(DATA_BITS - 1))
                   state_d = PARITY != PARITY_NONE ? ST_PARITY : ST_STOP;
      ST_PARITY: if (decide) state_d = ST_STOP;
      ST_STOP:   if (decide) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb busy = state_q != ST_IDLE;

  // Sample counter restarts on start detect so mid-bit lands OVERSAMPLE/2 ticks after the edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      vote_q   <= 2'b11;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      commit_q <= 1'b0;
      cperr_q  <= 1'b0;
      cferr_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx};
      commit_q <= stop_dec;
      if (start) cnt_q <= '0;
      else if (tick) cnt_q <= cnt_q == CW'(OVERSAMPLE - 1) ? '0 : cnt_q + 1'b1;
      if (tick && cnt_q == CW'(OVERSAMPLE / 2 - 1)) vote_q[0] <= rx_s;
      if (tick && cnt_q == CW'(OVERSAMPLE / 2)) vote_q[1] <= rx_s;
      if (start) bit_q <= '0;
      else if (decide && state_q == ST_DATA) bit_q <= bit_q + 1'b1;
      if (decide && state_q == ST_DATA) sh_q <= {bit_v, sh_q[DATA_BITS-1:1]};
      if (decide && state_q == ST_PARITY) par_q <= bit_v;
      if (stop_dec) begin
        cferr_q <= ~bit_v;
        cperr_q <= PARITY != PARITY_NONE && par_q != par_exp;
      end
    end

  // A low stop bit disarms start detection until the line has idled high for a bit time
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      armed_q <= 1'b0;
      hi_q    <= '0;
    end else if (stop_dec && !bit_v) begin
      armed_q <= 1'b0;
      hi_q    <= '0;
    end else if (!armed_q) begin
      if (!rx_s) hi_q <= '0;
      else if (tick) begin
        armed_q <= hi_q == CW'(OVERSAMPLE - 1);
        hi_q    <= hi_q == CW'(OVERSAMPLE - 1) ? '0 : hi_q + 1'b1;
      end
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dv_q   <= 1'b0;
      dout_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= commit_q && dv_q && !data_ready;
      if (commit_q && (!dv_q || data_ready)) begin
        dv_q   <= 1'b1;
        dout_q <= sh_q;
        perr_q <= cperr_q;
        ferr_q <= cferr_q;
      end else if (dv_q && data_ready) dv_q <= 1'b0;
    end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
`timescale 1ns/1ps
// tb_uart_rx_oversampled: bench BFM drives frames onto two receivers (8N1 and 8E1);
// accepted bytes are compared with a frame-level model of data, parity and stop rules.
module tb_uart_rx_oversampled;
  localparam int  CLK_FREQ = 50_000_000;
  localparam int  BAUD     = 781_250;
  localparam int  OS       = 16;
  localparam real CLK_NS   = 20.0;
  localparam real BIT_NS   = CLK_NS * OS * (CLK_FREQ / (BAUD * OS));

  logic clk = 1'b0, reset_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
  logic [7:0] dout0, dout1;
  logic dv0, pe0, fe0, ov0, busy0, dv1, pe1, fe1, ov1, busy1;

  int n_tests = 0, n_fail = 0;
  int ov0_n = 0, rise0 = 0;
  logic dv0_prev = 1'b0;
  logic [9:0] q0[$], q1[$];

  always #(CLK_NS / 2) clk = ~clk;

  uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                        .DATA_BITS(8), .PARITY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .rx(rx0), .data_out(dout0), .data_valid(dv0),
    .data_ready(rdy0), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(busy0));

  uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                        .DATA_BITS(8), .PARITY(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .rx(rx1), .data_out(dout1), .data_valid(dv1),
    .data_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(busy1));

  // Records every accepted byte as {frame_err, parity_err, data}
  always @(negedge clk) begin
    if (dv0 && rdy0) q0.push_back({fe0, pe0, dout0});
    if (dv1 && rdy1) q1.push_back({fe1, pe1, dout1});
    if (ov0) ov0_n++;
    if (dv0 && !dv0_prev) rise0++;
    dv0_prev = dv0;
  end

  function automatic logic [9:0] model(input logic [7:0] d, input int pmode, input logic pb,
                                       input logic sb);
    int ones = $countones(d) + int'(pb);
    logic pe = pmode == 0 ? 1'b0 : pmode == 1 ? (ones % 2 == 0) : (ones % 2 == 1);
    return {~sb, pe, d};
  endfunction

  task automatic drive(input int w, input logic v);
    if (w == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic send(input int w, input logic [7:0] d, input bit par, input logic pb,
                      input logic sb, input real sc);
    real bt = BIT_NS * sc;
    drive(w, 1'b0);
    #(bt);
    for (int i = 0; i < 8; i++) begin
      drive(w, d[i]);
      #(bt);
    end
    if (par) begin
      drive(w, pb);
      #(bt);
    end
    drive(w, sb);
    #(bt);
  endtask

  task automatic idle_bits(input real n);
    #(n * BIT_NS);
    @(negedge clk);
  endtask

  task automatic clear_mon();
    q0.delete();
    q1.delete();
    ov0_n = 0;
    rise0 = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (dv0 !== 1'b0) begin n_fail++; $display("FAIL reset_dv0: got %b want 0", dv0); end
    n_tests++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL reset_dout0: got %h want 00", dout0); end
    n_tests++; if ({pe0, fe0, ov0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags0: got %b want 000", {pe0, fe0, ov0}); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    n_tests++; if ({dv1, pe1, fe1, ov1, busy1} !== 5'b0) begin n_fail++; $display("FAIL reset_dut1: got %b want 00000", {dv1, pe1, fe1, ov1, busy1}); end
    reset_n = 1'b1;
    idle_bits(2);
  endtask

  task automatic test_basic();
    logic [9:0] exp = model(8'h55, 0, 1'b0, 1'b1);
    clear_mon();
    rdy0 = 1'b1;
    send(0, 8'h55, 0, 1'b0, 1'b1, 1.0);
    idle_bits(1);
    n_tests++; if (q0.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", q0.size()); end
    else begin n_tests++; if (q0[0] !== exp) begin n_fail++; $display("FAIL basic_frame: got %h want %h", q0[0], exp); end end
    n_tests++; if (rise0 != 1) begin n_fail++; $display("FAIL basic_pulse: got %0d want 1", rise0); end
    n_tests++; if (busy0 !== 1'b0 || dv0 !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy %b dv %b want 0 0", busy0, dv0); end
  endtask

  task automatic test_parity();
    logic [9:0] exp = model(8'hA3, 2, 1'b1, 1'b1);
    clear_mon();
    send(1, 8'hA3, 1, 1'b1, 1'b1, 1.0);
    idle_bits(1);
    n_tests++; if (q1.size() != 1) begin n_fail++; $display("FAIL parity_count: got %0d want 1", q1.size()); end
    else begin n_tests++; if (q1[0] !== exp) begin n_fail++; $display("FAIL parity_frame: got %h want %h", q1[0], exp); end end
  endtask

  task automatic test_break();
    logic [9:0] e0 = model(8'h0F, 0, 1'b0, 1'b0);
    logic [9:0] e1 = model(8'h96, 0, 1'b0, 1'b1);
    clear_mon();
    send(0, 8'h0F, 0, 1'b0, 1'b0, 1.0);
    #(3 * BIT_NS);
    @(negedge clk);
    n_tests++; if (q0.size() != 1) begin n_fail++; $display("FAIL break_count: got %0d want 1", q0.size()); end
    else begin n_tests++; if (q0[0] !== e0) begin n_fail++; $display("FAIL break_frame: got %h want %h", q0[0], e0); end end
    rx0 = 1'b1;
    #(BIT_NS / 2);
    send(0, 8'h00, 0, 1'b0, 1'b1, 1.0);
    idle_bits(2);
    n_tests++; if (q0.size() != 1) begin n_fail++; $display("FAIL break_unarmed: got %0d frames want 1", q0.size()); end
    send(0, 8'h96, 0, 1'b0, 1'b1, 1.0);
    idle_bits(1);
    n_tests++; if (q0.size() != 2) begin n_fail++; $display("FAIL break_rearm_count: got %0d want 2", q0.size()); end
    else begin n_tests++; if (q0[1] !== e1) begin n_fail++; $display("FAIL break_rearm_frame: got %h want %h", q0[1], e1); end end
  endtask

  task automatic test_glitch();
    clear_mon();
    @(negedge clk);
    rx0 = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b want 1", busy0); end
    repeat (10) @(negedge clk);
    rx0 = 1'b1;
    idle_bits(2);
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b want 0", busy0); end
    n_tests++; if (q0.size() != 0 || rise0 != 0) begin n_fail++; $display("FAIL glitch_no_frame: got %0d frames want 0", q0.size()); end
  endtask

  task automatic test_overrun();
    clear_mon();
    rdy0 = 1'b0;
    send(0, 8'h11, 0, 1'b0, 1'b1, 1.0);
    send(0, 8'h22, 0, 1'b0, 1'b1, 1.0);
    idle_bits(1);
    n_tests++; if (dv0 !== 1'b1) begin n_fail++; $display("FAIL ovr_held_valid: got %b want 1", dv0); end
    n_tests++; if (dout0 !== 8'h11) begin n_fail++; $display("FAIL ovr_held_data: got %h want 11", dout0); end
    n_tests++; if (ov0_n != 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d cycles want 1", ov0_n); end
    @(posedge clk);
    #1 rdy0 = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (q0.size() != 1) begin n_fail++; $display("FAIL ovr_accept_count: got %0d want 1", q0.size()); end
    else begin n_tests++; if (q0[0][7:0] !== 8'h11) begin n_fail++; $display("FAIL ovr_accept_data: got %h want 11", q0[0][7:0]); end end
    n_tests++; if (dv0 !== 1'b0 || dout0 !== 8'h11) begin n_fail++; $display("FAIL ovr_drop: dv %b data %h want 0 11", dv0, dout0); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp[$];
    logic [7:0] d;
    clear_mon();
    rdy0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      exp.push_back(model(d, 0, 1'b0, 1'b1));
      send(0, d, 0, 1'b0, 1'b1, 1.0);
    end
    idle_bits(1);
    n_tests++; if (q0.size() != exp.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", q0.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q0.size(); i++) begin
      n_tests++; if (q0[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_frame%0d: got %h want %h", i, q0[i], exp[i]); end
    end
  endtask

  task automatic test_random_parity();
    logic [9:0] exp[$];
    logic [7:0] d;
    logic pb, sb;
    clear_mon();
    rdy1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = $urandom_range(0, 3) != 0;
      exp.push_back(model(d, 2, pb, sb));
      send(1, d, 1, pb, sb, 1.0);
      rx1 = 1'b1;
      #(2 * BIT_NS);
    end
    @(negedge clk);
    n_tests++; if (q1.size() != exp.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", q1.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q1.size(); i++) begin
      n_tests++; if (q1[i] !== exp[i]) begin n_fail++; $display("FAIL rnd_frame%0d: got %h want %h", i, q1[i], exp[i]); end
    end
  endtask

  task automatic test_baud_tolerance();
    real sc[2] = '{1.02, 0.98};
    logic [9:0] exp = model(8'h55, 0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      clear_mon();
      send(0, 8'h55, 0, 1'b0, 1'b1, sc[i]);
      idle_bits(1);
      n_tests++; if (q0.size() != 1) begin n_fail++; $display("FAIL baud%0d_count: got %0d want 1", i, q0.size()); end
      else begin n_tests++; if (q0[0] !== exp) begin n_fail++; $display("FAIL baud%0d_frame: got %h want %h", i, q0[0], exp); end end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] exp = model(8'h3C, 0, 1'b0, 1'b1);
    clear_mon();
    fork
      send(0, 8'hC3, 0, 1'b0, 1'b1, 1.0);
      begin
        #(4 * BIT_NS);
        @(negedge clk);
        n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy0); end
        #3 reset_n = 1'b0;
        #2;
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy0); end
        n_tests++; if (dout0 !== 8'h00 || dv0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: data %h dv %b want 00 0", dout0, dv0); end
      end
    join
    idle_bits(1);
    reset_n = 1'b1;
    idle_bits(2);
    n_tests++; if (q0.size() != 0) begin n_fail++; $display("FAIL rstmid_partial: got %0d frames want 0", q0.size()); end
    send(0, 8'h3C, 0, 1'b0, 1'b1, 1.0);
    idle_bits(1);
    n_tests++; if (q0.size() != 1) begin n_fail++; $display("FAIL rstmid_after_count: got %0d want 1", q0.size()); end
    else begin n_tests++; if (q0[0] !== exp) begin n_fail++; $display("FAIL rstmid_after_frame: got %h want %h", q0[0], exp); end end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_random_parity();
    test_baud_tolerance();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
